// File: rtl/victim_cache_control.sv
// Victim cache controller: services L2 read/install requests,
// evicts dirty victims to physical memory and keeps hit/miss counters.
module victim_cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l2_read,
  input  logic                 l2_write,
  input  logic                 l2_wdirty,
  output logic                 l2_resp,
  output logic                 l2_rdirty,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 VC_hit,
  input  logic                 VC_hit_dirty,
  input  logic                 VC_LRU_dirty,
  input  logic [2:0]           hit_way,
  input  logic [23:0]          LRU_out,
  output logic [2:0]           data_index,
  output logic                 load_VC,
  output logic                 load_VC_dirty,
  output logic                 load_LRU,
  output logic                 VC_dirty_bit,
  output logic                 VC_write,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HIT,
    RD_ADDR,
    RD_FETCH,
    WR_HIT,
    WB_ADDR,
    WB_WRITE,
    INSTALL
  } state_t;

  state_t     state;
  logic [2:0] way_q;
  logic       accept;
  logic       hit_inc;
  logic       miss_inc;

  // Only the LRU way is consumed; the rest of the stack is datapath-owned.
  logic unused_lru;
  assign unused_lru = ^LRU_out[23:3];

  assign accept   = (state == IDLE) && (l2_read || l2_write);
  assign hit_inc  = accept && VC_hit;
  assign miss_inc = accept && !VC_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      way_q      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
      if (miss_inc && (miss_count != '1))
        miss_count <= miss_count + 1'b1;
      unique case (state)
        IDLE: begin
          if (accept)
            way_q <= VC_hit ? hit_way : LRU_out[2:0];
          if (l2_read)
            state <= VC_hit ? RD_HIT : RD_ADDR;
          else if (l2_write) begin
            if (VC_hit)
              state <= WR_HIT;
            else if (VC_LRU_dirty)
              state <= WB_ADDR;
            else
              state <= INSTALL;
          end
        end
        RD_HIT:   state <= IDLE;
        RD_ADDR:  state <= RD_FETCH;
        RD_FETCH: if (pmem_resp) state <= IDLE;
        WR_HIT:   state <= IDLE;
        WB_ADDR:  state <= WB_WRITE;
        WB_WRITE: if (pmem_resp) state <= INSTALL;
        INSTALL:  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode the current state so reset clears them at once.
  always_comb begin
    l2_resp       = 1'b0;
    l2_rdirty     = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_VC       = 1'b0;
    load_VC_dirty = 1'b0;
    load_LRU      = 1'b0;
    VC_dirty_bit  = 1'b0;
    VC_write      = 1'b0;
    data_index    = way_q;
    unique case (state)
      IDLE: data_index = LRU_out[2:0];
      RD_HIT: begin
        l2_resp   = 1'b1;
        l2_rdirty = VC_hit_dirty;
        load_LRU  = 1'b1;
      end
      RD_ADDR: ;
      RD_FETCH: begin
        pmem_read = 1'b1;
        l2_resp   = pmem_resp;
      end
      WR_HIT: begin
        load_VC       = 1'b1;
        load_VC_dirty = 1'b1;
        VC_dirty_bit  = l2_wdirty | VC_hit_dirty;
        load_LRU      = 1'b1;
        l2_resp       = 1'b1;
      end
      WB_ADDR:  VC_write   = 1'b1;
      WB_WRITE: pmem_write = 1'b1;
      INSTALL: begin
        load_VC       = 1'b1;
        load_VC_dirty = 1'b1;
        VC_dirty_bit  = l2_wdirty;
        load_LRU      = 1'b1;
        l2_resp       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/victim_cache_control.md
VICTIM_CACHE_CONTROL -- requirements
Module: victim_cache_control

Interface
REQ-001 Parameter: CNT_WIDTH, 16, width of the saturating hit and miss performance counters.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- l2_read  in  1  L2 request for a line (L2 missed); held until l2_resp.
- l2_write  in  1  L2 request to install an evicted line; held until l2_resp.
- l2_wdirty  in  1  the line being installed is dirty.
- l2_resp  out  1  one-cycle completion pulse to L2.
- l2_rdirty  out  1  the returned line is dirty; valid with l2_resp on a read.
- pmem_read, pmem_write  out  1 each  physical memory strobes; held until pmem_resp.
- pmem_resp  in  1  physical memory completion.
- VC_hit, VC_hit_dirty, VC_LRU_dirty  in  1 each  datapath lookup status.
- hit_way  in  3  hitting way.
- LRU_out  in  24  LRU stack; [23:21] is the MRU way, [2:0] is the LRU way.
- data_index  out  3  way select to the datapath.
- load_VC, load_VC_dirty, load_LRU  out  1 each  datapath write enables.
- VC_dirty_bit  out  1  dirty value to write.
- VC_write  out  1  1 = the address register captures the way address (writeback); 0 = it captures the L2 address.
- hit_count, miss_count  out  CNT_WIDTH each  performance counters.

Function
REQ-003 The block SHALL implement these states: IDLE, RD_HIT, RD_ADDR, RD_FETCH, WR_HIT, WB_ADDR, WB_WRITE, INSTALL.
REQ-004 In IDLE:
- data_index SHALL equal LRU_out[2:0].
- All strobes and enables SHALL be 0.
- VC_write SHALL be 0.
REQ-005 In IDLE, when l2_read and l2_write are both 1, l2_read SHALL be serviced first; l2_write stays pending.
REQ-006 In IDLE, on the cycle a request is accepted, the block SHALL latch the victim way into way_q:
- hit_way on a hit;
- otherwise LRU_out[2:0].
REQ-007 In every non-IDLE state, data_index SHALL equal way_q.
REQ-008 Read, VC_hit=1:
- IDLE -> RD_HIT.
- RD_HIT, one cycle: l2_resp=1, l2_rdirty=VC_hit_dirty, load_LRU=1.
- RD_HIT -> IDLE.
REQ-009 Read, VC_hit=0:
- IDLE -> RD_ADDR, one cycle with VC_write=0 so the address register loads the L2 address.
- RD_ADDR -> RD_FETCH.
- RD_FETCH: pmem_read=1 until pmem_resp; then l2_resp=1 and l2_rdirty=0 in the pmem_resp cycle, and the next state is IDLE.
- The victim cache contents and LRU SHALL NOT change.
REQ-010 Write, VC_hit=1:
- IDLE -> WR_HIT.
- WR_HIT, one cycle: load_VC=1, load_VC_dirty=1, VC_dirty_bit=l2_wdirty|VC_hit_dirty, load_LRU=1, l2_resp=1.
- WR_HIT -> IDLE.
REQ-011 Write, VC_hit=0, VC_LRU_dirty=0: the block SHALL go IDLE -> INSTALL.
REQ-012 Write, VC_hit=0, VC_LRU_dirty=1:
- IDLE -> WB_ADDR, one cycle with VC_write=1.
- WB_ADDR -> WB_WRITE.
- WB_WRITE: pmem_write=1 and VC_write=0 until pmem_resp.
- WB_WRITE -> INSTALL on pmem_resp.
REQ-013 INSTALL, one cycle:
- load_VC=1, load_VC_dirty=1, VC_dirty_bit=l2_wdirty, load_LRU=1, l2_resp=1.
- INSTALL -> IDLE.
REQ-014 pmem_resp SHALL be ignored in every state other than RD_FETCH and WB_WRITE.
REQ-015 Performance counters:
- hit_count SHALL increment on entry to RD_HIT or WR_HIT.
- miss_count SHALL increment on entry to RD_ADDR, WB_ADDR or INSTALL-from-IDLE.
- Both counters SHALL saturate at all-ones and never wrap.
REQ-016 l2_resp SHALL be asserted for exactly one cycle per accepted request, and never in IDLE.
REQ-017 A request deasserted before l2_resp is a protocol violation; behaviour in that case is unspecified.

Reset
REQ-018 When rst is asserted, at any time including mid-transaction, the block SHALL asynchronously:
- return to IDLE;
- clear way_q, hit_count and miss_count to 0;
- drive every strobe and enable output to 0 in the same cycle.
REQ-019 After rst deasserts, the block SHALL accept a new request on the first rising edge.

Verification
REQ-020 Read hit: l2_read=1, VC_hit=1, hit_way=5 -> next cycle l2_resp=1, data_index=5, load_LRU=1; hit_count=1.
REQ-021 Read miss: l2_read=1, VC_hit=0 -> one RD_ADDR cycle (VC_write=0), then pmem_read=1; pmem_resp after 4 cycles -> l2_resp in the same cycle, no load_VC; miss_count=1.
REQ-022 Dirty eviction: l2_write=1, l2_wdirty=0, VC_hit=0, LRU_out[2:0]=3, VC_LRU_dirty=1:
- WB_ADDR with VC_write=1, data_index=3;
- pmem_write held until pmem_resp;
- INSTALL with load_VC=1, VC_dirty_bit=0, l2_resp=1.
REQ-023 Simultaneous requests: l2_read=1 and l2_write=1 with VC_hit=1 -> RD_HIT first; after l2_read drops, the write completes via WR_HIT.
REQ-024 Reset mid-writeback: rst=1 during WB_WRITE -> pmem_write=0 immediately; state is IDLE; counters are 0; a later pmem_resp pulse is ignored.
REQ-025 Saturation: with CNT_WIDTH=4, 17 read hits -> hit_count=15.
